logic_pod_config_sequencer: RTL and testbench
=============================================

Name: logic_pod_config_sequencer

Overview:
Parametrised next-generation pod control-plane sequencer. Once hotswap power is enabled, it streams a host-loadable configuration script to a logic analyzer pod over the existing UART byte interface. Each newline-terminated line must be acknowledged by the pod; a NAK or a timeout causes the line to be retried, and the whole script can be re-sent on demand. One instance serves one pod and sits between the hotswap power control and the UART.

Parameters:
SCRIPT_DEPTH, 64, script RAM bytes (power of 2); AW = $clog2(SCRIPT_DEPTH)
POWERUP_CYCLES, 67108864, clk_125mhz cycles to wait after pod_power_en rises
ACK_TIMEOUT, 1250000, cycles to wait for an ack after a line's last byte completes (10 ms)
MAX_RETRIES, 3, resends allowed per line before fault
ACK_BYTE, 8'h2B, pod ack character '+'
NAK_BYTE, 8'h2D, pod nak character '-'

Ports:
clk_125mhz  in  1  sole clock
rst  in  1  synchronous, active-high reset
pod_power_en  in  1  from hotswap power control; high = pod powered
script_wr_en  in  1  script RAM write strobe
script_wr_addr  in  AW  write address
script_wr_data  in  8  write byte
script_len  in  AW+1  script length in bytes, 0..SCRIPT_DEPTH; sampled on entry to FETCH at line 0
reconfig  in  1  one-cycle request to resend the whole script
uart_tx_en  out  1  one-cycle byte-send strobe
uart_tx_data  out  8  byte to send, valid with uart_tx_en
uart_tx_done  in  1  UART finished the current byte
uart_rx_en  in  1  received-byte strobe
uart_rx_data  in  8  received byte
busy  out  1  sequence in progress (states POWERUP_WAIT through ACK_WAIT)
config_done  out  1  script fully acknowledged
config_fault  out  1  retries exhausted
total_retries  out  8  saturating count of resends since sequence start

Behaviour:
- Reset: state OFF. uart_tx_en=0, uart_tx_data=0, busy=0, config_done=0, config_fault=0, total_retries=0, all counters 0. The script RAM is not cleared.
- Script RAM: 8 x SCRIPT_DEPTH, one write port. Writes are accepted in any state and are visible to any later fetch. Synchronous read, 1-cycle latency.
- Registers: byte pointer ptr, line-start pointer line_start, per-line retry counter, timeout counter, power-up counter.
- States:
  - OFF: when pod_power_en=1, clear done/fault/total_retries and go to POWERUP_WAIT.
  - POWERUP_WAIT: count POWERUP_CYCLES cycles. Then ptr=line_start=0, and go to ON with config_done=1 if script_len==0, otherwise to FETCH.
  - FETCH: present ptr to the RAM for one cycle, then go to SEND.
  - SEND: drive uart_tx_en=1 for exactly one cycle with uart_tx_data = RAM data, then go to SEND_WAIT. uart_tx_en rises 2 cycles after FETCH is entered.
  - SEND_WAIT: on uart_tx_done, the line ends if the byte was 8'h0A or ptr == script_len-1.
    - Line ended: go to ACK_WAIT and clear the timeout counter.
    - Otherwise: ptr++ and go to FETCH.
  - ACK_WAIT: watch uart_rx_en and uart_rx_data.
    - ACK_BYTE: reset the retry counter. If ptr == script_len-1, set config_done and go to ON. Otherwise ptr = line_start = ptr+1 and go to FETCH.
    - NAK_BYTE, or timeout counter reaching ACK_TIMEOUT-1: if retry counter == MAX_RETRIES, set config_fault and go to FAULT. Otherwise increment the retry counter and total_retries (saturating at 255), set ptr=line_start, and go to FETCH.
    - Any other rx byte is ignored.
  - ON: idle. reconfig clears config_done and total_retries and restarts at line 0 via FETCH. POWERUP_WAIT is not repeated.
  - FAULT: idle with config_fault held. reconfig clears fault and retries, then restarts at line 0.
- reconfig is ignored in OFF, POWERUP_WAIT, FETCH, SEND, SEND_WAIT and ACK_WAIT.
- rx bytes outside ACK_WAIT are ignored. A stray uart_tx_done outside SEND_WAIT is ignored.
- pod_power_en=0 in any state: next state OFF, with done/fault cleared and uart_tx_en=0 the same cycle. Power loss beats a simultaneous reconfig, ack or tx_done. rst beats everything.
- busy=1 in POWERUP_WAIT, FETCH, SEND, SEND_WAIT and ACK_WAIT.
- Pointer arithmetic is AW+1 bits wide, so ptr never wraps; script_len=SCRIPT_DEPTH is legal.

Test Plan:
- POWERUP_CYCLES=100, script "a1\nv0\n" (len 6), pod acks '+' after each line -> UART bytes 61 31 0A 76 30 0A in order; ACK_WAIT entered twice; config_done=1; total_retries=0; first uart_tx_en 102 cycles after power-up.
- Same script, pod sends '-' once after line 1 -> bytes 61 31 0A 61 31 0A 76 30 0A; total_retries=1; config_done=1.
- ACK_TIMEOUT=50, MAX_RETRIES=2, pod silent -> line 1 sent 3 times; config_fault=1 after the third timeout; busy=0.
- In ON, pulse reconfig -> config_done drops the next cycle; full script re-sent; config_done=1 again after the final ack; no POWERUP_WAIT delay.
- Drop pod_power_en mid-SEND_WAIT -> state OFF next cycle; uart_tx_en=0, config_done=0. Restore power -> full power-up wait, then the script restarts from byte 0.
- script_len=0 -> ON with config_done=1 right after POWERUP_WAIT; no uart_tx_en ever. Script "ab" (len 2, no newline) with an ack -> treated as one line; config_done=1.

Source files
------------

// File: rtl/logic_pod_config_sequencer_if.sv
// UART byte-level link between the pod config sequencer (master) and the UART (slave).
// The master sends bytes and receives pod replies; the slave reports completion and received bytes.
interface logic_pod_config_sequencer_if;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_done;
    logic       uart_rx_en;
    logic [7:0] uart_rx_data;

    modport master (
        output uart_tx_en,
        output uart_tx_data,
        input  uart_tx_done,
        input  uart_rx_en,
        input  uart_rx_data
    );

    modport slave (
        input  uart_tx_en,
        input  uart_tx_data,
        output uart_tx_done,
        output uart_rx_en,
        output uart_rx_data
    );
endinterface

// File: rtl/logic_pod_config_sequencer.sv
// Streams a host-loaded configuration script to a powered pod line by line over the UART,
// retrying each line on NAK or ack timeout until the script is acknowledged or retries run out.
module logic_pod_config_sequencer #(
    parameter int          SCRIPT_DEPTH   = 64,
    parameter int          POWERUP_CYCLES = 67108864,
    parameter int          ACK_TIMEOUT    = 1250000,
    parameter int          MAX_RETRIES    = 3,
    parameter logic [7:0]  ACK_BYTE       = 8'h2B,
    parameter logic [7:0]  NAK_BYTE       = 8'h2D,
    localparam int         AW             = $clog2(SCRIPT_DEPTH)
) (
    input  logic                           clk_125mhz,
    input  logic                           rst,
    input  logic                           pod_power_en,
    input  logic                           script_wr_en,
    input  logic [AW-1:0]                  script_wr_addr,
    input  logic [7:0]                     script_wr_data,
    input  logic [AW:0]                    script_len,
    input  logic                           reconfig,
    logic_pod_config_sequencer_if.master   uart,
    output logic                           busy,
    output logic                           config_done,
    output logic                           config_fault,
    output logic [7:0]                     total_retries
);

    localparam int PW_W = $clog2(POWERUP_CYCLES + 1);
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RT_W = $clog2(MAX_RETRIES + 2);

    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   PTR_ZERO  = '0;
    localparam logic [PW_W-1:0] PU_LAST = PW_W'(POWERUP_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_OFF,
        S_POWERUP_WAIT,
        S_FETCH,
        S_SEND,
        S_SEND_WAIT,
        S_ACK_WAIT,
        S_ON,
        S_FAULT
    } state_t;

    state_t            state_reg,      state_next;
    logic [AW:0]       ptr_reg,        ptr_next;
    logic [AW:0]       line_start_reg, line_start_next;
    logic [AW:0]       len_reg,        len_next;
    logic [RT_W-1:0]   retry_reg,      retry_next;
    logic [TO_W-1:0]   to_cnt_reg,     to_cnt_next;
    logic [PW_W-1:0]   pu_cnt_reg,     pu_cnt_next;
    logic              tx_en_reg,      tx_en_next;
    logic [7:0]        tx_data_reg,    tx_data_next;
    logic              done_reg,       done_next;
    logic              fault_reg,      fault_next;
    logic [7:0]        total_reg,      total_next;

    logic [7:0]        script_mem [SCRIPT_DEPTH];
    logic [7:0]        rd_data_reg;
    logic              ptr_last;

    // Script RAM: one write port, registered read addressed by the byte pointer.
    always_ff @(posedge clk_125mhz) begin
        if (script_wr_en) begin
            script_mem[script_wr_addr] <= script_wr_data;
        end
        rd_data_reg <= script_mem[ptr_reg[AW-1:0]];
    end

    assign ptr_last = (ptr_reg == (len_reg - PTR_ONE));

    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            state_reg      <= S_OFF;
            ptr_reg        <= '0;
            line_start_reg <= '0;
            len_reg        <= '0;
            retry_reg      <= '0;
            to_cnt_reg     <= '0;
            pu_cnt_reg     <= '0;
            tx_en_reg      <= 1'b0;
            tx_data_reg    <= '0;
            done_reg       <= 1'b0;
            fault_reg      <= 1'b0;
            total_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            line_start_reg <= line_start_next;
            len_reg        <= len_next;
            retry_reg      <= retry_next;
            to_cnt_reg     <= to_cnt_next;
            pu_cnt_reg     <= pu_cnt_next;
            tx_en_reg      <= tx_en_next;
            tx_data_reg    <= tx_data_next;
            done_reg       <= done_next;
            fault_reg      <= fault_next;
            total_reg      <= total_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        line_start_next = line_start_reg;
        len_next        = len_reg;
        retry_next      = retry_reg;
        to_cnt_next     = to_cnt_reg;
        pu_cnt_next     = pu_cnt_reg;
        tx_en_next      = 1'b0;
        tx_data_next    = tx_data_reg;
        done_next       = done_reg;
        fault_next      = fault_reg;
        total_next      = total_reg;

        case (state_reg)
            S_OFF: begin
                if (pod_power_en) begin
                    pu_cnt_next = '0;
                    done_next   = 1'b0;
                    fault_next  = 1'b0;
                    total_next  = '0;
                    state_next  = S_POWERUP_WAIT;
                end
            end
            S_POWERUP_WAIT: begin
                if (pu_cnt_reg == PU_LAST) begin
                    ptr_next        = PTR_ZERO;
                    line_start_next = PTR_ZERO;
                    retry_next      = '0;
                    len_next        = script_len;
                    if (script_len == PTR_ZERO) begin
                        done_next  = 1'b1;
                        state_next = S_ON;
                    end else begin
                        state_next = S_FETCH;
                    end
                end else begin
                    pu_cnt_next = pu_cnt_reg + PW_W'(1);
                end
            end
            S_FETCH: begin
                state_next = S_SEND;
            end
            S_SEND: begin
                tx_en_next   = 1'b1;
                tx_data_next = rd_data_reg;
                state_next   = S_SEND_WAIT;
            end
            S_SEND_WAIT: begin
                if (uart.uart_tx_done) begin
                    if ((tx_data_reg == 8'h0A) || ptr_last) begin
                        to_cnt_next = '0;
                        state_next  = S_ACK_WAIT;
                    end else begin
                        ptr_next   = ptr_reg + PTR_ONE;
                        state_next = S_FETCH;
                    end
                end
            end
            S_ACK_WAIT: begin
                if (uart.uart_rx_en && (uart.uart_rx_data == ACK_BYTE)) begin
                    retry_next = '0;
                    if (ptr_last) begin
                        done_next  = 1'b1;
                        state_next = S_ON;
                    end else begin
                        ptr_next        = ptr_reg + PTR_ONE;
                        line_start_next = ptr_reg + PTR_ONE;
                        state_next      = S_FETCH;
                    end
                end else if ((uart.uart_rx_en && (uart.uart_rx_data == NAK_BYTE)) ||
                             (to_cnt_reg == TO_LAST)) begin
                    if (retry_reg == RT_MAX) begin
                        fault_next = 1'b1;
                        state_next = S_FAULT;
                    end else begin
                        retry_next = retry_reg + RT_W'(1);
                        if (total_reg != 8'hFF) begin
                            total_next = total_reg + 8'd1;
                        end
                        ptr_next   = line_start_reg;
                        state_next = S_FETCH;
                    end
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            S_ON, S_FAULT: begin
                if (reconfig) begin
                    done_next       = 1'b0;
                    fault_next      = 1'b0;
                    total_next      = '0;
                    retry_next      = '0;
                    ptr_next        = PTR_ZERO;
                    line_start_next = PTR_ZERO;
                    len_next        = script_len;
                    // An empty script has nothing to send, so it is immediately complete.
                    if (script_len == PTR_ZERO) begin
                        done_next  = 1'b1;
                        state_next = S_ON;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            default: begin
                state_next = S_OFF;
            end
        endcase

        // Losing pod power overrides every other event in the same cycle.
        if (!pod_power_en) begin
            state_next = S_OFF;
            done_next  = 1'b0;
            fault_next = 1'b0;
            tx_en_next = 1'b0;
        end
    end

    assign uart.uart_tx_en   = tx_en_reg;
    assign uart.uart_tx_data = tx_data_reg;
    assign config_done       = done_reg;
    assign config_fault      = fault_reg;
    assign total_retries     = total_reg;
    assign busy              = (state_reg == S_POWERUP_WAIT) || (state_reg == S_FETCH) ||
                               (state_reg == S_SEND) || (state_reg == S_SEND_WAIT) ||
                               (state_reg == S_ACK_WAIT);

endmodule

// File: tb/tb_logic_pod_config_sequencer.sv
// Bench for the pod config sequencer: a behavioural pod answers each line and a byte
// scoreboard checks the UART stream; scenario tasks check flags, counters and latencies.
module tb_logic_pod_config_sequencer;
    localparam int         DEPTH = 64;
    localparam int         AW    = 6;
    localparam int         PU    = 100;
    localparam int         TO    = 50;
    localparam int         MR    = 2;
    localparam logic [7:0] ACK   = 8'h2B;
    localparam logic [7:0] NAK   = 8'h2D;

    logic          clk_125mhz = 1'b0;
    logic          rst;
    logic          pod_power_en;
    logic          script_wr_en;
    logic [AW-1:0] script_wr_addr;
    logic [7:0]    script_wr_data;
    logic [AW:0]   script_len;
    logic          reconfig;
    logic          busy;
    logic          config_done;
    logic          config_fault;
    logic [7:0]    total_retries;

    logic_pod_config_sequencer_if uart_bus();

    logic_pod_config_sequencer #(
        .SCRIPT_DEPTH   (DEPTH),
        .POWERUP_CYCLES (PU),
        .ACK_TIMEOUT    (TO),
        .MAX_RETRIES    (MR),
        .ACK_BYTE       (ACK),
        .NAK_BYTE       (NAK)
    ) dut (
        .clk_125mhz     (clk_125mhz),
        .rst            (rst),
        .pod_power_en   (pod_power_en),
        .script_wr_en   (script_wr_en),
        .script_wr_addr (script_wr_addr),
        .script_wr_data (script_wr_data),
        .script_len     (script_len),
        .reconfig       (reconfig),
        .uart           (uart_bus),
        .busy           (busy),
        .config_done    (config_done),
        .config_fault   (config_fault),
        .total_retries  (total_retries)
    );

    always #4 clk_125mhz = ~clk_125mhz;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    int         tx_count  = 0;
    int         ack_waits = 0;
    bit         pod_silent = 1'b0;
    bit         hold_done  = 1'b0;
    int         nak_left   = 0;

    // Pod model: completes each byte, and answers once the sequencer stops sending for a while.
    initial begin
        int         idle;
        bit         armed;
        logic [7:0] b;
        logic [7:0] e;
        uart_bus.uart_tx_done = 1'b0;
        uart_bus.uart_rx_en   = 1'b0;
        uart_bus.uart_rx_data = 8'h00;
        armed = 1'b0;
        idle  = 0;
        forever begin
            @(posedge clk_125mhz);
            #1;
            if (uart_bus.uart_tx_en) begin
                b = uart_bus.uart_tx_data;
                tx_count++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL tx_byte: got %02h required no byte", b);
                end else begin
                    e = exp_q.pop_front();
                    if (b !== e) begin
                        bad++;
                        $display("FAIL tx_byte: got %02h required %02h", b, e);
                    end else begin
                        $display("tx byte %02h ok", b);
                    end
                end
                armed = 1'b0;
                idle  = 0;
                if (!hold_done) begin
                    @(posedge clk_125mhz);
                    #1 uart_bus.uart_tx_done = 1'b1;
                    @(posedge clk_125mhz);
                    #1 uart_bus.uart_tx_done = 1'b0;
                    armed = 1'b1;
                end
            end else if (armed) begin
                idle++;
                if (idle == 6) begin
                    armed = 1'b0;
                    idle  = 0;
                    ack_waits++;
                    if (!pod_silent) begin
                        if (nak_left > 0) begin
                            uart_bus.uart_rx_data = NAK;
                            nak_left--;
                        end else begin
                            uart_bus.uart_rx_data = ACK;
                        end
                        uart_bus.uart_rx_en = 1'b1;
                        $display("pod reply %02h", uart_bus.uart_rx_data);
                        @(posedge clk_125mhz);
                        #1 uart_bus.uart_rx_en = 1'b0;
                    end else begin
                        $display("pod silent");
                    end
                end
            end
        end
    end

    task automatic write_byte(input int addr, input logic [7:0] data);
        script_wr_en   = 1'b1;
        script_wr_addr = AW'(addr);
        script_wr_data = data;
        @(posedge clk_125mhz);
        #1 script_wr_en = 1'b0;
    endtask

    task automatic push_script6();
        exp_q.push_back(8'h61); exp_q.push_back(8'h31); exp_q.push_back(8'h0A);
        exp_q.push_back(8'h76); exp_q.push_back(8'h30); exp_q.push_back(8'h0A);
    endtask

    // n = edges (counting the first) until uart_tx_en is seen, or -1 on timeout.
    task automatic wait_tx_en(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk_125mhz);
            #1;
            n++;
        end while (!uart_bus.uart_tx_en && n < limit);
        if (!uart_bus.uart_tx_en) n = -1;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk_125mhz);
            #1;
            n++;
        end while (!config_done && n < limit);
        if (!config_done) n = -1;
    endtask

    task automatic wait_fault(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk_125mhz);
            #1;
            n++;
        end while (!config_fault && n < limit);
        if (!config_fault) n = -1;
    endtask

    task automatic pulse_reconfig();
        reconfig = 1'b1;
        @(posedge clk_125mhz);
        #1 reconfig = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (uart_bus.uart_tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en: got %b required 0", uart_bus.uart_tx_en); end
        total++; if (uart_bus.uart_tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %02h required 00", uart_bus.uart_tx_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        total++; if (config_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", config_done); end
        total++; if (config_fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b required 0", config_fault); end
        total++; if (total_retries !== 8'h00) begin bad++; $display("FAIL reset_retries: got %0d required 0", total_retries); end
        $display("reset checked");
    endtask

    task automatic test_basic();
        int n;
        int aw0;
        aw0 = ack_waits;
        push_script6();
        script_len   = 7'd6;
        pod_power_en = 1'b1;
        wait_tx_en(500, n);
        // Power sampled at edge 1; 100 power-up cycles, FETCH, SEND: strobe registered at edge 103.
        total++; if (n != PU + 3) begin bad++; $display("FAIL powerup_latency: got %0d required %0d", n, PU + 3); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b required 1", busy); end
        wait_done(2000, n);
        total++; if (n < 0) begin bad++; $display("FAIL basic_done_timeout: got none required config_done"); end
        total++; if (total_retries !== 8'd0) begin bad++; $display("FAIL basic_retries: got %0d required 0", total_retries); end
        total++; if (ack_waits - aw0 != 2) begin bad++; $display("FAIL basic_ack_waits: got %0d required 2", ack_waits - aw0); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_bytes_left: got %0d required 0", exp_q.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: got %b required 0", busy); end
    endtask

    task automatic test_reconfig();
        int n;
        push_script6();
        pulse_reconfig();
        total++; if (config_done !== 1'b0) begin bad++; $display("FAIL reconfig_done_drop: got %b required 0", config_done); end
        wait_tx_en(50, n);
        total++; if (n != 2) begin bad++; $display("FAIL reconfig_latency: got %0d required 2", n); end
        wait_done(2000, n);
        total++; if (n < 0) begin bad++; $display("FAIL reconfig_done_timeout: got none required config_done"); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL reconfig_bytes_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_nak();
        int n;
        exp_q.push_back(8'h61); exp_q.push_back(8'h31); exp_q.push_back(8'h0A);
        push_script6();
        nak_left = 1;
        pulse_reconfig();
        wait_done(3000, n);
        total++; if (n < 0) begin bad++; $display("FAIL nak_done_timeout: got none required config_done"); end
        total++; if (total_retries !== 8'd1) begin bad++; $display("FAIL nak_retries: got %0d required 1", total_retries); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL nak_bytes_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int n;
        int tc0;
        tc0 = tx_count;
        for (int i = 0; i <= MR; i++) begin
            exp_q.push_back(8'h61); exp_q.push_back(8'h31); exp_q.push_back(8'h0A);
        end
        pod_silent = 1'b1;
        pulse_reconfig();
        wait_fault(3000, n);
        total++; if (n < 0) begin bad++; $display("FAIL timeout_fault_timeout: got none required config_fault"); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b required 0", busy); end
        total++; if (config_done !== 1'b0) begin bad++; $display("FAIL timeout_done: got %b required 0", config_done); end
        total++; if (total_retries !== 8'(MR)) begin bad++; $display("FAIL timeout_retries: got %0d required %0d", total_retries, MR); end
        total++; if (tx_count - tc0 != 3 * (MR + 1)) begin bad++; $display("FAIL timeout_byte_count: got %0d required %0d", tx_count - tc0, 3 * (MR + 1)); end
        repeat (TO + 10) @(posedge clk_125mhz);
        #1;
        total++; if (config_fault !== 1'b1) begin bad++; $display("FAIL fault_held: got %b required 1", config_fault); end
        pod_silent = 1'b0;
    endtask

    task automatic test_fault_recover();
        int n;
        push_script6();
        pulse_reconfig();
        total++; if (config_fault !== 1'b0) begin bad++; $display("FAIL recover_fault_clear: got %b required 0", config_fault); end
        total++; if (total_retries !== 8'd0) begin bad++; $display("FAIL recover_retries_clear: got %0d required 0", total_retries); end
        wait_done(2000, n);
        total++; if (n < 0) begin bad++; $display("FAIL recover_done_timeout: got none required config_done"); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL recover_bytes_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_power_drop();
        int n;
        hold_done = 1'b1;
        exp_q.push_back(8'h61);
        pulse_reconfig();
        wait_tx_en(50, n);
        total++; if (n < 0) begin bad++; $display("FAIL drop_first_byte: got none required tx strobe"); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy_before: got %b required 1", busy); end
        pod_power_en = 1'b0;
        @(posedge clk_125mhz);
        #1;
        total++; if (uart_bus.uart_tx_en !== 1'b0) begin bad++; $display("FAIL drop_tx_en: got %b required 0", uart_bus.uart_tx_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy: got %b required 0", busy); end
        total++; if (config_done !== 1'b0) begin bad++; $display("FAIL drop_done: got %b required 0", config_done); end
        hold_done = 1'b0;
        push_script6();
        pod_power_en = 1'b1;
        wait_tx_en(500, n);
        total++; if (n != PU + 3) begin bad++; $display("FAIL repower_latency: got %0d required %0d", n, PU + 3); end
        wait_done(2000, n);
        total++; if (n < 0) begin bad++; $display("FAIL repower_done_timeout: got none required config_done"); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL repower_bytes_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_empty_script();
        int n;
        int tc0;
        tc0 = tx_count;
        script_len   = 7'd0;
        pod_power_en = 1'b0;
        @(posedge clk_125mhz);
        #1 pod_power_en = 1'b1;
        wait_done(500, n);
        // Done registers at the edge ending the 100th power-up cycle.
        total++; if (n != PU + 1) begin bad++; $display("FAIL empty_done_latency: got %0d required %0d", n, PU + 1); end
        repeat (20) @(posedge clk_125mhz);
        #1;
        total++; if (tx_count != tc0) begin bad++; $display("FAIL empty_no_tx: got %0d bytes required 0", tx_count - tc0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty_busy: got %b required 0", busy); end
    endtask

    task automatic test_no_newline();
        int n;
        int aw0;
        write_byte(0, 8'h61);
        write_byte(1, 8'h62);
        script_len = 7'd2;
        aw0 = ack_waits;
        exp_q.push_back(8'h61); exp_q.push_back(8'h62);
        pulse_reconfig();
        wait_done(2000, n);
        total++; if (n < 0) begin bad++; $display("FAIL nonl_done_timeout: got none required config_done"); end
        total++; if (ack_waits - aw0 != 1) begin bad++; $display("FAIL nonl_ack_waits: got %0d required 1", ack_waits - aw0); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL nonl_bytes_left: got %0d required 0", exp_q.size()); end
    endtask

    initial begin
        rst            = 1'b1;
        pod_power_en   = 1'b0;
        script_wr_en   = 1'b0;
        script_wr_addr = '0;
        script_wr_data = '0;
        script_len     = '0;
        reconfig       = 1'b0;
        repeat (3) @(posedge clk_125mhz);
        #1;
        test_reset();
        rst = 1'b0;
        write_byte(0, 8'h61); write_byte(1, 8'h31); write_byte(2, 8'h0A);
        write_byte(3, 8'h76); write_byte(4, 8'h30); write_byte(5, 8'h0A);
        test_basic();
        test_reconfig();
        test_nak();
        test_timeout();
        test_fault_recover();
        test_power_drop();
        test_empty_script();
        test_no_newline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
